// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive path: byte width, buffer defaults,
// the armed-flag state type and a depth helper used by the FIFO.
package uart_rx_buffer_pkg;

   localparam int UART_BYTE_W         = 8;
   localparam int DBIT_DEFAULT        = UART_BYTE_W;
   localparam int ADDR_W_DEFAULT      = 4;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic {
      DISARMED = 1'b0,
      ARMED    = 1'b1
   } arm_state_t;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Bundle of the receiver-facing and CPU-facing signals of the receive buffer.
// The buffer itself connects through the slave modport.
interface uart_rx_buffer_if #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
);

   logic              rx_done;
   logic [DBIT-1:0]   rx_dato_out;
   logic              rd;
   logic              clr_overrun;
   logic [DBIT-1:0]   r_data;
   logic              rx_empty;
   logic              rx_full;
   logic              overrun;
   logic [ADDR_W:0]   count;

   modport master (
      output rx_done, rx_dato_out, rd, clr_overrun,
      input  r_data, rx_empty, rx_full, overrun, count
   );

   modport slave (
      input  rx_done, rx_dato_out, rd, clr_overrun,
      output r_data, rx_empty, rx_full, overrun, count
   );

endinterface

// File: rtl/uart_rx_buffer_sync_edge_detect.sv
// Brings an asynchronous level onto clk through a flop chain and emits a
// one-cycle pulse on each rising edge. Pulses are only produced once the
// synchronized level has been seen low after reset, so a level that is
// already high when reset releases is never mistaken for an edge.
module sync_edge_detect
   import uart_rx_buffer_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   s_sync;
   logic                   s_prev;
   logic                   sync_valid;
   arm_state_t             arm_q;
   arm_state_t             arm_d;

   assign s_sync     = sync_q[SYNC_STAGES-1];
   assign sync_valid = fill_q[SYNC_STAGES-1];

   // Shift the async level through the synchronizer, track when the chain
   // holds real samples rather than reset zeros, and keep one history flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         fill_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         s_prev <= s_sync;
      end
   end

   // Armed flag register; reset leaves the detector disarmed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= DISARMED;
      end else begin
         arm_q <= arm_d;
      end
   end

   // Arm on the first genuine low sample, then pulse on every rising edge.
   always_comb begin
      arm_d = arm_q;
      pulse = 1'b0;
      if (arm_q == DISARMED && sync_valid && !s_sync) begin
         arm_d = ARMED;
      end
      if (arm_q == ARMED && s_sync && !s_prev) begin
         pulse = 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind the UART receiver: synchronizes the done tick,
// captures each byte into a show-ahead FIFO and reports occupancy and a
// sticky overrun flag to the reading side.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int DBIT        = DBIT_DEFAULT,
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_buffer_if.slave bus
);

   localparam int            DEPTH      = fifo_depth(ADDR_W);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [DBIT-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overrun_q;

   logic push;
   logic pop;
   logic wr_en;
   logic overrun_set;
   logic empty;
   logic full;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_done_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.rx_done),
      .pulse    (push)
   );

   // Status flags and the push/pop decisions. A push into a full FIFO only
   // goes ahead when a pop frees the slot in the same cycle; otherwise the
   // byte is dropped and flagged.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == FULL_COUNT);
      pop         = bus.rd & ~empty;
      wr_en       = push & (~full | pop);
      overrun_set = push & full & ~pop;
   end

   // Pointers wrap naturally at the FIFO depth; occupancy only moves when
   // exactly one of push or pop happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
            2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overrun: a dropped byte sets it and wins over a clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (overrun_set) begin
         overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
         overrun_q <= 1'b0;
      end
   end

   // Byte storage; the receiver holds its data long after done rises, so the
   // byte is taken straight from rx_dato_out on the push edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.rx_dato_out;
      end
   end

   assign bus.r_data   = mem[rd_ptr];
   assign bus.rx_empty = empty;
   assign bus.rx_full  = full;
   assign bus.overrun  = overrun_q;
   assign bus.count    = count_q;

endmodule
